// File: rtl/processor_pkg.sv
// Shared encodings for the single-cycle ARMv4-subset core: instruction fields, flags and
// the condition-code evaluator.
package processor_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_EOR = 4'b0001,
        CMD_SUB = 4'b0010,
        CMD_RSB = 4'b0011,
        CMD_ADD = 4'b0100,
        CMD_CMP = 4'b1010,
        CMD_ORR = 4'b1100,
        CMD_MOV = 4'b1101
    } cmd_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic cond_pass(input cond_e cond, input flags_t f);
        case (cond)
            COND_EQ: return f.z;
            COND_NE: return !f.z;
            COND_CS: return f.c;
            COND_CC: return !f.c;
            COND_MI: return f.n;
            COND_PL: return !f.n;
            COND_VS: return f.v;
            COND_VC: return !f.v;
            COND_HI: return f.c && !f.z;
            COND_LS: return !f.c || f.z;
            COND_GE: return f.n == f.v;
            COND_LT: return f.n != f.v;
            COND_GT: return !f.z && (f.n == f.v);
            COND_LE: return f.z || (f.n != f.v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic cmd_known(input cmd_e cmd);
        case (cmd)
            CMD_AND, CMD_EOR, CMD_SUB, CMD_RSB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU: data-processing operations and NZCV generation.
module processor_alu
    import processor_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  cmd_e            cmd,
    input  logic            shift_c,
    input  flags_t          flags_in,
    output logic [XLEN-1:0] result,
    output flags_t          flags_out
);

    logic [XLEN:0] sum;

    always_comb begin
        sum       = '0;
        result    = '0;
        flags_out = flags_in;
        flags_out.c = shift_c;
        case (cmd)
            CMD_AND: result = a & b;
            CMD_EOR: result = a ^ b;
            CMD_ORR: result = a | b;
            CMD_MOV: result = b;
            CMD_ADD: begin
                sum         = {1'b0, a} + {1'b0, b};
                result      = sum[XLEN-1:0];
                flags_out.c = sum[XLEN];
                flags_out.v = (a[XLEN-1] == b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
            end
            CMD_SUB, CMD_CMP: begin
                // carry out of a + ~b + 1 is NOT borrow
                sum         = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
                result      = sum[XLEN-1:0];
                flags_out.c = sum[XLEN];
                flags_out.v = (a[XLEN-1] != b[XLEN-1]) && (result[XLEN-1] != a[XLEN-1]);
            end
            CMD_RSB: begin
                sum         = {1'b0, b} + {1'b0, ~a} + {{XLEN{1'b0}}, 1'b1};
                result      = sum[XLEN-1:0];
                flags_out.c = sum[XLEN];
                flags_out.v = (b[XLEN-1] != a[XLEN-1]) && (result[XLEN-1] != b[XLEN-1]);
            end
            default: result = '0;
        endcase
        flags_out.n = result[XLEN-1];
        flags_out.z = (result == '0);
    end

endmodule

// File: rtl/processor_core.sv
// Single-cycle ARMv4-subset core: decode, register file, condition check and commit of
// regs/flags/pc on each rising clock.
module processor_core
    import processor_pkg::*;
#(
    parameter int unsigned PC_W = 8,
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] readData,
    output logic [PC_W-1:0] pc,
    output logic [XLEN-1:0] address,
    output logic [XLEN-1:0] writeData,
    output logic            WR,
    output logic            MemtoRegOut
);

    logic [XLEN-1:0] regs_q [15];
    logic [XLEN-1:0] regs_d [15];
    logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
    flags_t          flags_q, flags_d, alu_flags;

    op_e             op;
    cond_e           cond;
    cmd_e            cmd, alu_cmd;
    shift_e          sh_type;
    logic [3:0]      rn_idx, rd_idx, rm_idx;
    logic [4:0]      shamt, rot;
    logic [XLEN-1:0] rn_val, rd_val, rm_val, pc_plus8;
    logic [XLEN-1:0] op2, alu_a, alu_b, alu_y;
    logic [2*XLEN-1:0] rot_tmp;
    logic [XLEN:0]   lsl_tmp;
    logic            shift_c, cond_ok, is_store, is_load;
    logic            unused_reg_shift;

    assign op       = op_e'(instruction[27:26]);
    assign cond     = cond_e'(instruction[31:28]);
    assign cmd      = cmd_e'(instruction[24:21]);
    assign sh_type  = shift_e'(instruction[6:5]);
    assign rn_idx   = instruction[19:16];
    assign rd_idx   = instruction[15:12];
    assign rm_idx   = instruction[3:0];
    assign shamt    = instruction[11:7];
    assign rot      = {instruction[11:8], 1'b0};
    assign unused_reg_shift = instruction[4];

    assign pc_plus4 = pc_q + PC_W'(4);
    assign pc_plus8 = XLEN'(pc_q) + XLEN'(8);
    assign cond_ok  = cond_pass(cond, flags_q);

    // r15 has no storage; any index not matched by r0..r14 reads as pc+8
    always_comb begin
        rn_val = pc_plus8;
        rd_val = pc_plus8;
        rm_val = pc_plus8;
        for (int unsigned i = 0; i < 15; i++) begin
            if (rn_idx == 4'(i)) rn_val = regs_q[i];
            if (rd_idx == 4'(i)) rd_val = regs_q[i];
            if (rm_idx == 4'(i)) rm_val = regs_q[i];
        end
    end

    always_comb begin
        shift_c = flags_q.c;
        rot_tmp = '0;
        lsl_tmp = '0;
        op2     = rm_val;
        if (instruction[25]) begin
            rot_tmp = {XLEN'(instruction[7:0]), XLEN'(instruction[7:0])} >> rot;
            op2     = rot_tmp[XLEN-1:0];
            if (rot != '0) shift_c = op2[XLEN-1];
        end else if (shamt != '0) begin
            case (sh_type)
                SH_LSL: begin
                    lsl_tmp = {1'b0, rm_val} << shamt;
                    op2     = lsl_tmp[XLEN-1:0];
                    shift_c = lsl_tmp[XLEN];
                end
                SH_LSR: begin
                    op2     = rm_val >> shamt;
                    shift_c = rm_val[shamt - 5'd1];
                end
                SH_ASR: begin
                    op2     = $unsigned($signed(rm_val) >>> shamt);
                    shift_c = rm_val[shamt - 5'd1];
                end
                default: begin
                    rot_tmp = {rm_val, rm_val} >> shamt;
                    op2     = rot_tmp[XLEN-1:0];
                    shift_c = op2[XLEN-1];
                end
            endcase
        end
    end

    always_comb begin
        alu_a   = rn_val;
        alu_b   = op2;
        alu_cmd = cmd;
        case (op)
            OP_MEM: begin
                alu_b   = XLEN'(instruction[11:0]);
                alu_cmd = instruction[23] ? CMD_ADD : CMD_SUB;
            end
            OP_BR: begin
                alu_b   = XLEN'(instruction[23:0]);
                alu_cmd = CMD_MOV;
            end
            default: ;
        endcase
    end

    processor_alu #(.XLEN(XLEN)) u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .cmd       (alu_cmd),
        .shift_c   (shift_c),
        .flags_in  (flags_q),
        .result    (alu_y),
        .flags_out (alu_flags)
    );

    always_comb begin
        pc_d    = pc_plus4;
        flags_d = flags_q;
        regs_d  = regs_q;
        if (cond_ok) begin
            case (op)
                OP_DP: begin
                    if (cmd_known(cmd) && cmd != CMD_CMP) begin
                        for (int unsigned i = 0; i < 15; i++)
                            if (rd_idx == 4'(i)) regs_d[i] = alu_y;
                    end
                    if (cmd == CMD_CMP || (instruction[20] && cmd_known(cmd))) flags_d = alu_flags;
                end
                OP_MEM: begin
                    if (instruction[20]) begin
                        for (int unsigned i = 0; i < 15; i++)
                            if (rd_idx == 4'(i)) regs_d[i] = readData;
                    end
                end
                OP_BR: begin
                    pc_d = instruction[PC_W-1:0];
                    if (instruction[24]) regs_d[14] = XLEN'(pc_plus4);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            flags_q <= '0;
            for (int unsigned i = 0; i < 15; i++) regs_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
            for (int unsigned i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign is_store    = cond_ok && (op == OP_MEM) && !instruction[20];
    assign is_load     = cond_ok && (op == OP_MEM) && instruction[20];
    assign WR          = !rst && is_store;
    assign MemtoRegOut = !rst && is_load;
    assign pc          = pc_q;
    assign address     = alu_y;
    assign writeData   = rd_val;

endmodule

// File: tb/tb_processor_core.sv
// Directed-vector bench for processor_core with hand-computed expected values.
module tb_processor_core;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] readData;
    logic [7:0]  pc;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        WR;
    logic        MemtoRegOut;

    int unsigned checks = 0;
    int unsigned errors = 0;

    processor_core #(.PC_W(8), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .readData    (readData),
        .pc          (pc),
        .address     (address),
        .writeData   (writeData),
        .WR          (WR),
        .MemtoRegOut (MemtoRegOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic present(input logic [31:0] ins);
        instruction = ins;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        readData    = 32'h0;
        instruction = 32'hE1A00000;
        tick();
        rst = 1'b0;
        check_eq("reset_pc", {24'b0, pc}, 32'h0);
        check_eq("reset_flags", {28'b0, dut.flags_q}, 32'h0);

        present(32'hE3A00002);
        check_eq("mov_r0_2", address, 32'd2);
        tick();
        check_eq("pc_4", {24'b0, pc}, 32'h4);
        present(32'hE2800002);
        check_eq("add_r0_2", address, 32'd4);
        tick();
        check_eq("pc_8", {24'b0, pc}, 32'h8);

        present(32'hE3A01002); tick();
        present(32'hE3A02003); tick();
        present(32'hE0813002);
        check_eq("add_r3_r1_r2", address, 32'd5);
        tick();
        present(32'hE1530000); tick();
        check_eq("cmp_gt_flags", {28'b0, dut.flags_q}, 32'b0010);

        present(32'hCA00002C); tick();
        check_eq("bgt_taken", {24'b0, pc}, 32'h2C);
        present(32'hBA00003C); tick();
        check_eq("blt_not_taken", {24'b0, pc}, 32'h30);

        present(32'hE1520000); tick();
        check_eq("cmp_lt_flags", {28'b0, dut.flags_q}, 32'b1000);
        present(32'hCA00004C); tick();
        check_eq("bgt_fail", {24'b0, pc}, 32'h38);
        present(32'hBA00005C); tick();
        check_eq("blt_taken", {24'b0, pc}, 32'h5C);
        present(32'hEA00006C); tick();
        check_eq("b_always", {24'b0, pc}, 32'h6C);
        present(32'hE2800002);
        check_eq("add_r0_6", address, 32'd6);
        tick();
        check_eq("pc_70", {24'b0, pc}, 32'h70);

        present(32'hE5801004);
        check_eq("str_wr", {31'b0, WR}, 32'd1);
        check_eq("str_addr", address, 32'd10);
        check_eq("str_data", writeData, 32'd2);
        check_eq("str_m2r", {31'b0, MemtoRegOut}, 32'd0);
        tick();

        readData = 32'hDEADBEEF;
        present(32'hE5904000);
        check_eq("ldr_m2r", {31'b0, MemtoRegOut}, 32'd1);
        check_eq("ldr_wr", {31'b0, WR}, 32'd0);
        check_eq("ldr_addr", address, 32'd6);
        tick();
        readData = 32'h0;
        present(32'hE2845000);
        check_eq("ldr_result_r4", address, 32'hDEADBEEF);
        tick();

        present(32'hE0813102);
        check_eq("add_lsl2", address, 32'd14);
        tick();
        check_eq("pc_80", {24'b0, pc}, 32'h80);
        present(32'hE1A0700F);
        check_eq("read_r15", address, 32'h88);
        tick();
        present(32'hE3A004FF);
        check_eq("imm_rotate", address, 32'hFF000000);
        tick();
        present(32'hE1A0B0C0);
        check_eq("asr_1", address, 32'hFF800000);
        tick();
        present(32'hE0518001);
        check_eq("subs_zero", address, 32'h0);
        tick();
        check_eq("subs_flags", {28'b0, dut.flags_q}, 32'b0110);
        check_eq("pc_90", {24'b0, pc}, 32'h90);

        present(32'hEB0000F8); tick();
        check_eq("bl_target", {24'b0, pc}, 32'hF8);
        present(32'hE1A0A00E);
        check_eq("bl_link_r14", address, 32'h94);
        tick();
        present(32'hE3A00001); tick();
        check_eq("pc_wrap", {24'b0, pc}, 32'h0);
        present(32'hE5114001);
        check_eq("ldr_down_addr", address, 32'd1);
        tick();

        rst = 1'b1;
        present(32'hE5801004);
        check_eq("rst_wr_low", {31'b0, WR}, 32'd0);
        tick();
        rst = 1'b0;
        check_eq("rst_mid_pc", {24'b0, pc}, 32'h0);
        check_eq("rst_mid_flags", {28'b0, dut.flags_q}, 32'h0);
        present(32'hE2809000);
        check_eq("rst_mid_r0", address, 32'h0);
        tick();
        present(32'h05801000);
        check_eq("streq_fail_wr", {31'b0, WR}, 32'd0);
        tick();
        check_eq("cond_fail_pc", {24'b0, pc}, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
